// File: rtl/gemm_tile_pkg.sv
// Shared types and width helpers for the systolic GEMM tile.
package gemm_tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Bits needed to hold a reduction length in 0..k_max.
    function automatic int k_len_width(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    // Bits needed to index a row; never narrower than one bit.
    function automatic int row_idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/gemm_mac_pe.sv
// One output-stationary processing element: accumulates a*b and forwards
// its operands east (a) and south (b) through registers.
module gemm_mac_pe
    import gemm_tile_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         en,
    input  logic                         clr,
    input  logic signed [DATA_WIDTH-1:0] a_west,
    input  logic signed [DATA_WIDTH-1:0] b_north,
    output logic signed [DATA_WIDTH-1:0] a_east,
    output logic signed [DATA_WIDTH-1:0] b_south,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   a_reg;
    logic signed [DATA_WIDTH-1:0]   b_reg;
    logic signed [ACC_WIDTH-1:0]    acc_reg;

    assign prod    = a_west * b_north;
    assign a_east  = a_reg;
    assign b_south = b_reg;
    assign acc     = acc_reg;

    // Accumulate the sign-extended product and pass operands on, only on enabled steps.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            acc_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + ACC_WIDTH'(prod);
            a_reg   <= a_west;
            b_reg   <= b_north;
        end
    end

endmodule

// File: rtl/systolic_gemm_tile.sv
// ROWS x COLS output-stationary systolic GEMM tile with operand skewing,
// valid/ready streams and an IDLE/LOAD/FLUSH/DRAIN control FSM.
module systolic_gemm_tile
    import gemm_tile_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int K_MAX      = 256,
    localparam int KW        = k_len_width(K_MAX),
    localparam int RW        = row_idx_width(ROWS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [KW-1:0]             k_len_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0] a_data_i,
    input  logic [COLS*DATA_WIDTH-1:0] b_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [COLS*ACC_WIDTH-1:0] out_data_o,
    output logic [RW-1:0]             out_row_o,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int FLUSH_LEN = ROWS + COLS - 2;
    localparam int FW        = $clog2(ROWS + COLS);

    state_t            state_reg, state_next;
    logic [KW-1:0]     k_len_reg, beat_cnt_reg, k_len_clamped;
    logic [FW-1:0]     flush_cnt_reg;
    logic [RW-1:0]     row_cnt_reg;
    logic              done_reg;
    logic              start_acc, beat_acc, step_en, row_acc, last_row;

    logic [ROWS-1:0][DATA_WIDTH-1:0]           a_inj, a_skew;
    logic [COLS-1:0][DATA_WIDTH-1:0]           b_inj, b_skew;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] a_east, b_south;
    logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0]  acc;

    assign k_len_clamped = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
    assign start_acc     = (state_reg == ST_IDLE) && start_i;
    assign beat_acc      = (state_reg == ST_LOAD) && in_valid_i;
    assign step_en       = beat_acc || (state_reg == ST_FLUSH);
    assign row_acc       = (state_reg == ST_DRAIN) && out_ready_i;
    assign last_row      = (row_cnt_reg == RW'(ROWS - 1));

    // Zero operands are injected whenever the array steps outside LOAD (flush).
    assign a_inj = (state_reg == ST_LOAD) ? a_data_i : '0;
    assign b_inj = (state_reg == ST_LOAD) ? b_data_i : '0;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_i)
                          state_next = (k_len_clamped == '0) ? ST_DRAIN : ST_LOAD;
            ST_LOAD:  if (beat_acc && (beat_cnt_reg == k_len_reg - KW'(1)))
                          state_next = (FLUSH_LEN == 0) ? ST_DRAIN : ST_FLUSH;
            ST_FLUSH: if (flush_cnt_reg == FW'(FLUSH_LEN - 1))
                          state_next = ST_DRAIN;
            ST_DRAIN: if (out_ready_i && last_row)
                          state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Beat, flush and row counters plus the registered completion pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_len_reg     <= '0;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            row_cnt_reg   <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= row_acc && last_row;
            if (start_acc) begin
                k_len_reg     <= k_len_clamped;
                beat_cnt_reg  <= '0;
                flush_cnt_reg <= '0;
                row_cnt_reg   <= '0;
            end
            if (beat_acc)                beat_cnt_reg  <= beat_cnt_reg + KW'(1);
            if (state_reg == ST_FLUSH)   flush_cnt_reg <= flush_cnt_reg + FW'(1);
            if (row_acc)                 row_cnt_reg   <= last_row ? '0 : row_cnt_reg + RW'(1);
        end
    end

    // Outputs derived from state; payload is the accumulator row under the row counter.
    always_comb begin
        in_ready_o  = (state_reg == ST_LOAD);
        out_valid_o = (state_reg == ST_DRAIN);
        busy_o      = (state_reg != ST_IDLE);
        done_o      = done_reg;
        out_data_o  = '0;
        out_row_o   = '0;
        out_last_o  = 1'b0;
        if (state_reg == ST_DRAIN) begin
            out_row_o  = row_cnt_reg;
            out_last_o = last_row;
            for (int c = 0; c < COLS; c++)
                out_data_o[c*ACC_WIDTH +: ACC_WIDTH] = acc[row_cnt_reg][c];
        end
    end

    genvar gi, gj;

    // A lane r is delayed r array steps so that step k meets B at PE(r,c) on step k+r+c.
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
        if (gi == 0) begin : g_direct
            assign a_skew[gi] = a_inj[gi];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly_reg [gi];
            // Enable-gated shift register, cleared on tile start.
            always_ff @(posedge clk_i) begin
                if (rst_i || start_acc) begin
                    for (int j = 0; j < gi; j++) dly_reg[j] <= '0;
                end else if (step_en) begin
                    dly_reg[0] <= a_inj[gi];
                    for (int j = 1; j < gi; j++) dly_reg[j] <= dly_reg[j-1];
                end
            end
            assign a_skew[gi] = dly_reg[gi-1];
        end
    end

    // B lane c is delayed c array steps.
    for (gi = 0; gi < COLS; gi++) begin : g_b_skew
        if (gi == 0) begin : g_direct
            assign b_skew[gi] = b_inj[gi];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly_reg [gi];
            // Enable-gated shift register, cleared on tile start.
            always_ff @(posedge clk_i) begin
                if (rst_i || start_acc) begin
                    for (int j = 0; j < gi; j++) dly_reg[j] <= '0;
                end else if (step_en) begin
                    dly_reg[0] <= b_inj[gi];
                    for (int j = 1; j < gi; j++) dly_reg[j] <= dly_reg[j-1];
                end
            end
            assign b_skew[gi] = dly_reg[gi-1];
        end
    end

    // PE grid: A enters from the west edge, B from the north edge.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            logic [DATA_WIDTH-1:0] a_west, b_north;
            if (gj == 0) begin : g_a_edge
                assign a_west = a_skew[gi];
            end else begin : g_a_link
                assign a_west = a_east[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_north = b_skew[gj];
            end else begin : g_b_link
                assign b_north = b_south[gi-1][gj];
            end
            gemm_mac_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk     (clk_i),
                .srst    (rst_i),
                .en      (step_en),
                .clr     (start_acc),
                .a_west  (a_west),
                .b_north (b_north),
                .a_east  (a_east[gi][gj]),
                .b_south (b_south[gi][gj]),
                .acc     (acc[gi][gj])
            );
        end
    end

endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Self-checking bench for systolic_gemm_tile: a directed 2x2 tile plus
// randomized 4x4 tiles checked against a plain matrix-product model.
module tb_systolic_gemm_tile;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam int KM = 16;
    localparam int KW = $clog2(KM + 1);
    localparam int NB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 4x4 tile
    logic            start, in_valid, out_ready;
    logic [KW-1:0]   k_len;
    logic [R*DW-1:0] a_data;
    logic [C*DW-1:0] b_data;
    logic            in_ready, out_valid, out_last, busy, done;
    logic [C*AW-1:0] out_data;
    logic [1:0]      out_row;

    // 2x2 tile
    logic            s_start, s_in_valid, s_out_ready;
    logic [KW-1:0]   s_k_len;
    logic [2*DW-1:0] s_a_data, s_b_data;
    logic            s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
    logic [2*AW-1:0] s_out_data;
    logic [0:0]      s_out_row;

    int tests = 0;
    int fails = 0;

    shortint mat_a [R][NB];
    shortint mat_b [NB][C];

    systolic_gemm_tile #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .a_data_i(a_data), .b_data_i(b_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_row_o(out_row), .out_last_o(out_last), .busy_o(busy), .done_o(done)
    );

    systolic_gemm_tile #(.ROWS(2), .COLS(2), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .k_len_i(s_k_len),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .a_data_i(s_a_data), .b_data_i(s_b_data),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
        .out_row_o(s_out_row), .out_last_o(s_out_last), .busy_o(s_busy), .done_o(s_done)
    );

    task automatic chk(input string tag, input logic [C*AW-1:0] got, input logic [C*AW-1:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < R; r++)
            for (int k = 0; k < NB; k++) mat_a[r][k] = shortint'($urandom);
        for (int k = 0; k < NB; k++)
            for (int c = 0; c < C; c++) mat_b[k][c] = shortint'($urandom);
    endtask

    task automatic fill_const(input shortint av, input shortint bv);
        for (int r = 0; r < R; r++)
            for (int k = 0; k < NB; k++) mat_a[r][k] = av;
        for (int k = 0; k < NB; k++)
            for (int c = 0; c < C; c++) mat_b[k][c] = bv;
    endtask

    // Runs one 4x4 tile starting at the current falling edge. gap/bp are
    // percentages of idle input / withheld ready; noise pulses start_i while busy.
    task automatic run_tile(input string name, input int klen_req, input int gap,
                            input int bp, input bit noise);
        int              keff, idx, rows_seen, cyc, stalls, exp_cyc;
        bit              stall_prev;
        logic [C*AW-1:0] held_data, exp_row;
        logic [1:0]      held_row;
        logic [AW-1:0]   exp_c [R][C];
        longint          s;

        keff = (klen_req > KM) ? KM : klen_req;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                s = 0;
                for (int k = 0; k < keff; k++)
                    s += longint'(mat_a[r][k]) * longint'(mat_b[k][c]);
                exp_c[r][c] = s[AW-1:0];
            end

        start = 1'b1;
        k_len = klen_req[KW-1:0];
        in_valid = 1'b0;
        out_ready = 1'b0;
        idx = 0; rows_seen = 0; cyc = 0; stalls = 0; stall_prev = 1'b0;
        held_data = '0; held_row = '0;

        while (rows_seen < R && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = noise && busy && ($urandom_range(0, 3) == 0);
            chk({name, " no_early_done"}, done, 0);
            in_valid = (idx < NB) ? ($urandom_range(0, 99) >= gap) : 1'b0;
            for (int r = 0; r < R; r++) a_data[r*DW +: DW] = (idx < NB) ? mat_a[r][idx] : '0;
            for (int c = 0; c < C; c++) b_data[c*DW +: DW] = (idx < NB) ? mat_b[idx][c] : '0;
            if (in_ready && !in_valid) stalls++;
            if (in_ready && in_valid) idx++;
            if (stall_prev) begin
                chk({name, " stable_data"}, out_data, held_data);
                chk({name, " stable_row"}, out_row, held_row);
            end
            out_ready = ($urandom_range(0, 99) >= bp);
            stall_prev = 1'b0;
            if (out_valid) begin
                if (!out_ready) begin
                    stalls++;
                    stall_prev = 1'b1;
                    held_data = out_data;
                    held_row = out_row;
                end else begin
                    for (int c = 0; c < C; c++) exp_row[c*AW +: AW] = exp_c[rows_seen][c];
                    chk({name, " row_idx"}, out_row, rows_seen);
                    chk({name, " row_last"}, out_last, (rows_seen == R - 1));
                    chk({name, " row_data"}, out_data, exp_row);
                    $display("[TB] %s row %0d data=%h", name, rows_seen, out_data);
                    rows_seen++;
                end
            end
        end
        chk({name, " rows_drained"}, rows_seen, R);
        @(negedge clk);
        cyc++;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_cyc = ((keff == 0) ? (1 + R) : (keff + R + C - 1 + R)) + stalls;
        chk({name, " done"}, done, 1);
        chk({name, " idle_after"}, busy, 0);
        chk({name, " beats"}, idx, keff);
        chk({name, " latency"}, cyc, exp_cyc);
        $display("[TB] %s k=%0d beats=%0d cycles=%0d stalls=%0d", name, klen_req, idx, cyc, stalls);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0; a_data = '0; b_data = '0;
        s_start = 1'b0; s_k_len = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        s_a_data = '0; s_b_data = '0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_row", out_row, 0);
        chk("rst out_last", out_last, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst2 busy", s_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed 2x2, K=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]].
        s_start = 1'b1; s_k_len = KW'(2);
        @(negedge clk);
        s_start = 1'b0;
        chk("2x2 in_ready", s_in_ready, 1);
        s_in_valid = 1'b1; s_a_data = {16'd3, 16'd1}; s_b_data = {16'd6, 16'd5};
        @(negedge clk);
        s_a_data = {16'd4, 16'd2}; s_b_data = {16'd8, 16'd7};
        @(negedge clk);
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        for (int m = 3; m <= 8; m++) begin
            chk("2x2 out_valid", s_out_valid, (m == 5 || m == 6));
            chk("2x2 done", s_done, (m == 7));
            if (m == 5) begin
                chk("2x2 row0", s_out_data, {40'd22, 40'd19});
                chk("2x2 row0 last", s_out_last, 0);
            end
            if (m == 6) begin
                chk("2x2 row1", s_out_data, {40'd50, 40'd43});
                chk("2x2 row1 idx", s_out_row, 1);
                chk("2x2 row1 last", s_out_last, 1);
            end
            $display("[TB] 2x2 t+%0d valid=%0b done=%0b data=%h", m, s_out_valid, s_done, s_out_data);
            @(negedge clk);
        end
        s_out_ready = 1'b0;

        // Sign extremes with K=1.
        fill_const(-16'sd32768, -16'sd32768);
        run_tile("minxmin", 1, 0, 0, 1'b0);
        fill_const(-16'sd3, 16'sd7);
        run_tile("neg21", 1, 0, 0, 1'b0);

        // Random tiles back-to-back (start in the done cycle), with gaps, backpressure, start noise.
        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_tile("rand", 8, 30, 40, 1'b1);
        end

        // Zero-length tile drains zeros; oversize length clamps to K_MAX.
        run_tile("k0", 0, 0, 30, 1'b1);
        fill_random();
        run_tile("clamp", KM + 5, 20, 20, 1'b0);

        // Reset in the middle of LOAD after three beats.
        fill_random();
        start = 1'b1; k_len = KW'(8);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < R; r++) a_data[r*DW +: DW] = mat_a[r][b];
            for (int c = 0; c < C; c++) b_data[c*DW +: DW] = mat_b[b][c];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready", in_ready, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_data", out_data, 0);
        chk("midrst out_row", out_row, 0);
        chk("midrst out_last", out_last, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        fill_random();
        run_tile("after_rst", 8, 25, 25, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
